// File: rtl/ws2812b_pkg.sv
// Shared constants, state encoding and frame-length helper for the WS2812B
// controller/sequencer pair.
package ws2812b_pkg;

    localparam int BIT_CYCLES     = 61;
    localparam int T_RESET_CYCLES = 3250;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LATCH,
        WAIT
    } state_t;

    // Shortest frame that fits the load burst, the latch, the serial
    // transfer of every LED and the WS2812B reset gap.
    function automatic int min_frame_cycles(input int nb_leds);
        return nb_leds + 1 + 24 * nb_leds * BIT_CYCLES + T_RESET_CYCLES;
    endfunction

endpackage

// File: rtl/ring_pattern_gen.sv
// Combinational comet pattern: full colour at the head, quarter colour on the
// LED trailing behind it, black elsewhere.
module ring_pattern_gen #(
    parameter int NB_LEDS = 12
) (
    input  logic [7:0] address,
    input  logic [7:0] position,
    input  logic       direction,
    input  logic [7:0] color_r,
    input  logic [7:0] color_g,
    input  logic [7:0] color_b,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam logic [7:0] LED_LAST = 8'(NB_LEDS - 1);

    logic [7:0] tail;

    always_comb begin
        if (direction) begin
            tail = (position == LED_LAST) ? 8'd0 : position + 8'd1;
        end else begin
            tail = (position == 8'd0) ? LED_LAST : position - 8'd1;
        end

        red   = 8'd0;
        green = 8'd0;
        blue  = 8'd0;
        // Head test comes first so it wins when head and tail coincide.
        if (address == position) begin
            red   = color_r;
            green = color_g;
            blue  = color_b;
        end else if (address == tail) begin
            red   = color_r >> 2;
            green = color_g >> 2;
            blue  = color_b >> 2;
        end
    end

endmodule

// File: rtl/ws2812b_ring_sequencer.sv
// Frame scheduler for a rotating comet on a WS2812B ring: loads every LED,
// latches once, then waits out the transfer and reset gap.
module ws2812b_ring_sequencer
    import ws2812b_pkg::*;
#(
    parameter int NB_LEDS      = 12,
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int STEP_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       direction,
    input  logic [7:0] color_r,
    input  logic [7:0] color_g,
    input  logic [7:0] color_b,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] address,
    output logic       load,
    output logic       latch_n,
    output logic [7:0] position,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0]  LED_LAST  = 8'(NB_LEDS - 1);
    localparam logic [7:0]  STEP_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [23:0] LOAD_LAST = 24'(NB_LEDS - 1);
    localparam logic [23:0] CYC_LAST  = 24'(FRAME_CYCLES - 1);
    localparam logic [23:0] CYC_PRE   = 24'(FRAME_CYCLES - 2);

    if (NB_LEDS < 1 || NB_LEDS > 255) begin : g_bad_nb_leds
        $error("NB_LEDS must be in 1..255");
    end
    if (STEP_FRAMES < 1 || STEP_FRAMES > 256) begin : g_bad_step
        $error("STEP_FRAMES must be in 1..256");
    end
    if (FRAME_CYCLES < min_frame_cycles(NB_LEDS) || FRAME_CYCLES > 2**24) begin : g_bad_frame
        $error("FRAME_CYCLES too short for NB_LEDS or exceeds the 24-bit counter");
    end

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic        guard;
    logic [7:0]  step_cnt, step_n, pos_n;
    logic        last_cycle, step_now, start;

    logic [7:0]  fr_r, fr_g, fr_b, fr_pos;
    logic        fr_dir;
    logic [7:0]  fr_r_n, fr_g_n, fr_b_n, fr_pos_n;
    logic        fr_dir_n;
    logic [7:0]  pat_r, pat_g, pat_b;

    assign last_cycle = (state == WAIT) && (cnt == CYC_LAST);
    // The guard WAIT after reset ends a frame that never loaded: no step.
    assign step_now   = last_cycle && !guard;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 24'd1;
        unique case (state)
            IDLE: begin
                cnt_n = cnt;
                if (enable) begin
                    state_n = LOAD;
                    cnt_n   = 24'd0;
                end
            end
            LOAD:  if (cnt == LOAD_LAST) state_n = LATCH;
            LATCH: state_n = WAIT;
            WAIT: begin
                if (last_cycle) begin
                    state_n = enable ? LOAD : IDLE;
                    cnt_n   = 24'd0;
                end
            end
            default: state_n = WAIT;
        endcase
    end

    always_comb begin
        step_n = step_cnt;
        pos_n  = position;
        if (step_now) begin
            if (step_cnt == STEP_LAST) begin
                step_n = 8'd0;
                if (fr_dir) begin
                    pos_n = (position == 8'd0) ? LED_LAST : position - 8'd1;
                end else begin
                    pos_n = (position == LED_LAST) ? 8'd0 : position + 8'd1;
                end
            end else begin
                step_n = step_cnt + 8'd1;
            end
        end
    end

    // Frame registers capture on entry to LOAD; position uses its stepped value.
    assign start    = (state_n == LOAD) && (state != LOAD);
    assign fr_r_n   = start ? color_r   : fr_r;
    assign fr_g_n   = start ? color_g   : fr_g;
    assign fr_b_n   = start ? color_b   : fr_b;
    assign fr_dir_n = start ? direction : fr_dir;
    assign fr_pos_n = start ? pos_n     : fr_pos;

    ring_pattern_gen #(
        .NB_LEDS (NB_LEDS)
    ) u_pattern (
        .address   (cnt_n[7:0]),
        .position  (fr_pos_n),
        .direction (fr_dir_n),
        .color_r   (fr_r_n),
        .color_g   (fr_g_n),
        .color_b   (fr_b_n),
        .red       (pat_r),
        .green     (pat_g),
        .blue      (pat_b)
    );

    always_ff @(posedge clk) begin
        fr_r   <= fr_r_n;
        fr_g   <= fr_g_n;
        fr_b   <= fr_b_n;
        fr_dir <= fr_dir_n;
        fr_pos <= fr_pos_n;
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT;
            cnt        <= 24'd0;
            guard      <= 1'b1;
            step_cnt   <= 8'd0;
            position   <= 8'd0;
            load       <= 1'b0;
            latch_n    <= 1'b1;
            address    <= 8'd0;
            red        <= 8'd0;
            green      <= 8'd0;
            blue       <= 8'd0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            guard      <= guard && !last_cycle;
            step_cnt   <= step_n;
            position   <= pos_n;
            load       <= (state_n == LOAD);
            latch_n    <= (state_n != LATCH);
            address    <= (state_n == LOAD) ? cnt_n[7:0] : 8'd0;
            red        <= (state_n == LOAD) ? pat_r : 8'd0;
            green      <= (state_n == LOAD) ? pat_g : 8'd0;
            blue       <= (state_n == LOAD) ? pat_b : 8'd0;
            busy       <= (state_n != IDLE);
            frame_done <= (state == WAIT) && (cnt == CYC_PRE) && !guard;
        end
    end

endmodule

// File: tb/tb_ws2812b_ring_sequencer.sv
// Directed bench: a 12-LED instance for frame timing, enable and reset
// behaviour, plus two small rings running alongside for stepping and direction.
module tb_ws2812b_ring_sequencer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       a_reset, a_enable, a_direction;
    logic [7:0] a_cr, a_cg, a_cb;
    logic [7:0] a_red, a_green, a_blue, a_address, a_position;
    logic       a_load, a_latch_n, a_busy, a_frame_done;

    logic       bc_reset, bc_enable, b_direction, c_direction;
    logic [7:0] bc_cr, bc_cg, bc_cb;
    logic [7:0] b_red, b_green, b_blue, b_address, b_position;
    logic       b_load, b_latch_n, b_busy, b_frame_done;
    logic [7:0] c_red, c_green, c_blue, c_address, c_position;
    logic       c_load, c_latch_n, c_busy, c_frame_done;

    ws2812b_ring_sequencer #(.NB_LEDS(12), .FRAME_CYCLES(21000), .STEP_FRAMES(4)) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .direction(a_direction),
        .color_r(a_cr), .color_g(a_cg), .color_b(a_cb),
        .red(a_red), .green(a_green), .blue(a_blue), .address(a_address),
        .load(a_load), .latch_n(a_latch_n), .position(a_position),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    ws2812b_ring_sequencer #(.NB_LEDS(2), .FRAME_CYCLES(6200), .STEP_FRAMES(4)) dut_b (
        .clk(clk), .reset(bc_reset), .enable(bc_enable), .direction(b_direction),
        .color_r(bc_cr), .color_g(bc_cg), .color_b(bc_cb),
        .red(b_red), .green(b_green), .blue(b_blue), .address(b_address),
        .load(b_load), .latch_n(b_latch_n), .position(b_position),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    ws2812b_ring_sequencer #(.NB_LEDS(3), .FRAME_CYCLES(7650), .STEP_FRAMES(1)) dut_c (
        .clk(clk), .reset(bc_reset), .enable(bc_enable), .direction(c_direction),
        .color_r(bc_cr), .color_g(bc_cg), .color_b(bc_cb),
        .red(c_red), .green(c_green), .blue(c_blue), .address(c_address),
        .load(c_load), .latch_n(c_latch_n), .position(c_position),
        .busy(c_busy), .frame_done(c_frame_done)
    );

    int a_falls = 0;
    always @(negedge a_latch_n) a_falls++;

    int b_q[$];
    always @(negedge clk) if (b_load && b_address == 8'd0) b_q.push_back(int'(b_position));

    int          c_q[$];
    int          c_frames = 0;
    logic [23:0] c_cols[2][3];
    always @(negedge clk) begin
        if (c_load) begin
            if (c_address == 8'd0) begin
                c_q.push_back(int'(c_position));
                c_frames++;
            end
            if (c_frames >= 1 && c_frames <= 2 && c_address < 8'd3)
                c_cols[c_frames-1][int'(c_address)] = {c_red, c_green, c_blue};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; bc_reset = 1'b1;
        a_enable = 1'b0; a_direction = 1'b0;
        a_cr = 8'h00; a_cg = 8'h00; a_cb = 8'h00;
        bc_enable = 1'b0; b_direction = 1'b0; c_direction = 1'b1;
        bc_cr = 8'h40; bc_cg = 8'h80; bc_cb = 8'hFF;
        repeat (3) tick();
        total++;
        if ({a_load, a_latch_n, a_busy, a_frame_done} !== 4'b0110) begin
            bad++;
            $display("FAIL reset_ctrl: got load/latch_n/busy/frame_done=%b want 0110",
                     {a_load, a_latch_n, a_busy, a_frame_done});
        end
        total++;
        if ({a_address, a_red, a_green, a_blue, a_position} !== 40'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h rgb=%h%h%h pos=%h want all zero",
                     a_address, a_red, a_green, a_blue, a_position);
        end
        a_enable = 1'b1; a_cr = 8'h40; a_cg = 8'h80; a_cb = 8'hFF;
        bc_enable = 1'b1;
        a_reset = 1'b0; bc_reset = 1'b0;
    endtask

    task automatic check_load_burst(input string name, input logic [23:0] head,
                                    input logic [23:0] tailc, input int drop_at);
        logic [23:0] exp;
        for (int k = 0; k < 12; k++) begin
            exp = (k == 0) ? head : (k == 11) ? tailc : 24'd0;
            total++;
            if ({a_load, a_address, a_red, a_green, a_blue} !== {1'b1, 8'(k), exp}) begin
                bad++;
                $display("FAIL %s_addr%0d: got load=%b addr=%0d rgb=%h%h%h want load=1 addr=%0d rgb=%h",
                         name, k, a_load, a_address, a_red, a_green, a_blue, k, exp);
            end
            if (k == drop_at) a_enable = 1'b0;
            tick();
        end
        total++;
        if ({a_load, a_latch_n} !== 2'b00) begin
            bad++;
            $display("FAIL %s_latch: got load/latch_n=%b want 00", name, {a_load, a_latch_n});
        end
        tick();
        total++;
        if ({a_load, a_latch_n, a_busy} !== 3'b011) begin
            bad++;
            $display("FAIL %s_wait: got load/latch_n/busy=%b want 011", name, {a_load, a_latch_n, a_busy});
        end
    endtask

    task automatic wait_frame_done(input string name);
        int n = 13;
        while (!a_frame_done && n < 21100) begin
            tick();
            n++;
        end
        total++;
        if (n != 20999) begin
            bad++;
            $display("FAIL %s_frame_done: got offset %0d want 20999", name, n);
        end
    endtask

    task automatic test_first_frame();
        int n = 0;
        int fd = 0;
        int falls0;
        while (!a_load && n < 25000) begin
            tick();
            n++;
            if (a_frame_done) fd++;
        end
        total++;
        if (n != 21000) begin
            bad++;
            $display("FAIL first_load_delay: got %0d cycles want 21000", n);
        end
        total++;
        if (fd != 0) begin
            bad++;
            $display("FAIL guard_frame_done: got %0d pulses want 0", fd);
        end
        falls0 = a_falls;
        check_load_burst("frame1", 24'h4080FF, 24'h10203F, -1);
        a_cr = 8'hFF; a_cg = 8'h00; a_cb = 8'h00;
        wait_frame_done("frame1");
        total++;
        if (a_falls - falls0 != 1) begin
            bad++;
            $display("FAIL frame1_latch_edges: got %0d want 1", a_falls - falls0);
        end
        total++;
        if (a_position !== 8'd0) begin
            bad++;
            $display("FAIL frame1_position: got %0d want 0", a_position);
        end
        tick();
    endtask

    task automatic test_enable_drop();
        check_load_burst("frame2", 24'hFF0000, 24'h3F0000, 5);
        wait_frame_done("frame2");
        tick();
        total++;
        if ({a_busy, a_load, a_latch_n} !== 3'b001) begin
            bad++;
            $display("FAIL enable_drop_idle: got busy/load/latch_n=%b want 001", {a_busy, a_load, a_latch_n});
        end
        total++;
        if (a_position !== 8'd0) begin
            bad++;
            $display("FAIL frame2_position: got %0d want 0", a_position);
        end
    endtask

    task automatic test_idle_latency();
        repeat (3) tick();
        total++;
        if ({a_busy, a_load} !== 2'b00) begin
            bad++;
            $display("FAIL idle_hold: got busy/load=%b want 00", {a_busy, a_load});
        end
        a_enable = 1'b1;
        tick();
        total++;
        if ({a_busy, a_load, a_address, a_red, a_green, a_blue} !== {2'b11, 8'd0, 24'hFF0000}) begin
            bad++;
            $display("FAIL idle_to_load: got busy=%b load=%b addr=%0d rgb=%h%h%h want busy=1 load=1 addr=0 rgb=ff0000",
                     a_busy, a_load, a_address, a_red, a_green, a_blue);
        end
    endtask

    task automatic test_reset_mid_load();
        int falls0;
        logic seen_load = 1'b0;
        repeat (6) tick();
        total++;
        if ({a_load, a_address} !== {1'b1, 8'd6}) begin
            bad++;
            $display("FAIL pre_reset_addr: got load=%b addr=%0d want load=1 addr=6", a_load, a_address);
        end
        #3 a_reset = 1'b1;
        #1;
        total++;
        if ({a_load, a_latch_n, a_busy, a_address, a_red} !== {3'b011, 16'd0}) begin
            bad++;
            $display("FAIL async_reset: got load=%b latch_n=%b busy=%b addr=%0d red=%h want 0,1,1,0,00",
                     a_load, a_latch_n, a_busy, a_address, a_red);
        end
        falls0 = a_falls;
        tick();
        a_reset = 1'b0;
        repeat (20999) begin
            tick();
            if (a_load) seen_load = 1'b1;
        end
        total++;
        if (a_falls != falls0 || seen_load) begin
            bad++;
            $display("FAIL reset_guard: got %0d latch edges load_seen=%b want 0 edges no load",
                     a_falls - falls0, seen_load);
        end
        tick();
        total++;
        if (a_load !== 1'b1) begin
            bad++;
            $display("FAIL reset_guard_end: got load=%b want 1", a_load);
        end
    endtask

    task automatic test_step();
        int exp_b[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        total++;
        if (b_q.size() < 12) begin
            bad++;
            $display("FAIL step_frames: got %0d frames want at least 12", b_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (b_q[i] != exp_b[i]) begin
                    bad++;
                    $display("FAIL step_pos_frame%0d: got %0d want %0d", i + 1, b_q[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_direction();
        int exp_c[8] = '{0, 2, 1, 0, 2, 1, 0, 2};
        logic [23:0] exp_cols[2][3] = '{'{24'h4080FF, 24'h10203F, 24'h000000},
                                        '{24'h10203F, 24'h000000, 24'h4080FF}};
        total++;
        if (c_q.size() < 8) begin
            bad++;
            $display("FAIL dir_frames: got %0d frames want at least 8", c_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (c_q[i] != exp_c[i]) begin
                    bad++;
                    $display("FAIL dir_pos_frame%0d: got %0d want %0d", i + 1, c_q[i], exp_c[i]);
                end
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (c_cols[f][k] !== exp_cols[f][k]) begin
                    bad++;
                    $display("FAIL dir_colour_f%0d_a%0d: got %h want %h", f + 1, k, c_cols[f][k], exp_cols[f][k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_enable_drop();
        test_idle_latency();
        test_reset_mid_load();
        test_step();
        test_direction();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
